// File: rtl/sim_ctrl_pkg.sv
// Shared definitions for the simulation-control slave.
// Holds register offsets (addr[3:2] index), STATUS bit positions, the FSM state type
// and the exit code forced by the watchdog.
package sim_ctrl_pkg;

  // Register select values, i.e. addr_i[3:2]
  localparam logic [1:0] SIM_CTRL_EXIT   = 2'd0;
  localparam logic [1:0] SIM_CTRL_TXDATA = 2'd1;
  localparam logic [1:0] SIM_CTRL_STATUS = 2'd2;
  localparam logic [1:0] SIM_CTRL_CYCLE  = 2'd3;

  // STATUS register layout
  localparam int unsigned STATUS_EMPTY_BIT   = 0;
  localparam int unsigned STATUS_FULL_BIT    = 1;
  localparam int unsigned STATUS_DONE_BIT    = 2;
  localparam int unsigned STATUS_TIMEOUT_BIT = 3;
  localparam int unsigned STATUS_LEVEL_LSB   = 8;

  localparam logic [30:0] EXIT_CODE_TIMEOUT = '1;

  typedef enum logic [1:0] {
    StRun,
    StDrain,
    StDone
  } state_e;

endpackage

// File: rtl/sim_ctrl_fifo.sv
// Synchronous FIFO used for the console TX path.
// Ports: clk_i/rst_ni clock and async active-low reset; push/wdata enqueue;
// pop dequeues; rdata is the head entry; full/empty/level report occupancy.
// Pointers carry one extra wrap bit so full and empty can be told apart.
module sim_ctrl_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wptr_q, rptr_q;
  logic             do_push, do_pop;

  assign empty   = (wptr_q == rptr_q);
  assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign level   = wptr_q - rptr_q;
  assign rdata   = mem_q[rptr_q[AW-1:0]];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
    end
  end

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/sim_ctrl_dev.sv
// Simulation-control slave: firmware reports test completion and streams console bytes.
// Ports: clk_i/rst_ni clock and async active-low reset; req_i/we_i/be_i/addr_i/data_i bus
// request; gnt_o/rvalid_o/data_o bus handshake and read data; tx_valid_o/tx_data_o/
// tx_ready_i console byte stream; done_o/pass_o/timeout_o/exit_code_o test result.
module sim_ctrl_dev
  import sim_ctrl_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH     = 8,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd1_000_000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  output logic        gnt_o,
  output logic        rvalid_o,
  output logic [31:0] data_o,
  output logic        tx_valid_o,
  output logic [7:0]  tx_data_o,
  input  logic        tx_ready_i,
  output logic        done_o,
  output logic        pass_o,
  output logic        timeout_o,
  output logic [30:0] exit_code_o
);

  localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [63:0] TimeoutLast = 64'(TIMEOUT_CYCLES) - 64'd1;

  state_e        state_q, state_d;
  logic [63:0]   cycle_q;
  logic          rvalid_q;
  logic [31:0]   rdata_q, rdata_d;
  logic          done_q, done_d, pass_q, pass_d, timeout_q, timeout_d;
  logic [30:0]   exit_code_q, exit_code_d;

  logic [1:0]    reg_sel;
  logic          is_tx_wr, push, pop, exit_wr, timeout_hit;
  logic [7:0]    fifo_rdata;
  logic          fifo_full, fifo_empty;
  logic [LW-1:0] fifo_level;
  logic [31:0]   status;
  logic          unused_bits;

  assign unused_bits = ^{addr_i[31:4], addr_i[1:0], be_i[3:1]};

  assign reg_sel  = addr_i[3:2];
  assign is_tx_wr = req_i && we_i && (reg_sel == SIM_CTRL_TXDATA);
  // A pop in the same cycle does not release the stall; only the registered level counts.
  assign gnt_o    = req_i && !(is_tx_wr && (state_q == StRun) && fifo_full);
  assign push     = gnt_o && is_tx_wr && (state_q == StRun) && be_i[0];
  assign pop      = tx_valid_o && tx_ready_i;
  assign exit_wr  = gnt_o && we_i && (reg_sel == SIM_CTRL_EXIT) && (state_q == StRun);
  assign timeout_hit = (TIMEOUT_CYCLES != 32'd0) && (state_q == StRun) &&
                       (cycle_q == TimeoutLast);

  sim_ctrl_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push   (push),
    .wdata  (data_i[7:0]),
    .pop    (pop),
    .rdata  (fifo_rdata),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .level  (fifo_level)
  );

  assign tx_valid_o = !fifo_empty;
  assign tx_data_o  = fifo_empty ? 8'h00 : fifo_rdata;

  always_comb begin
    status = '0;
    status[STATUS_EMPTY_BIT]        = fifo_empty;
    status[STATUS_FULL_BIT]         = fifo_full;
    status[STATUS_DONE_BIT]         = done_q;
    status[STATUS_TIMEOUT_BIT]      = timeout_q;
    status[STATUS_LEVEL_LSB +: 8]   = 8'(fifo_level);
  end

  // Read data is captured at grant time so the response reflects that cycle's state.
  always_comb begin
    rdata_d = '0;
    if (gnt_o && !we_i) begin
      case (reg_sel)
        SIM_CTRL_STATUS: rdata_d = status;
        SIM_CTRL_CYCLE:  rdata_d = cycle_q[31:0];
        default:         rdata_d = '0;
      endcase
    end
  end

  // FSM: state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= StRun;
    else         state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRun:   if (exit_wr || timeout_hit) state_d = StDrain;
      // Counts as drained in the cycle the last byte leaves.
      StDrain: if (fifo_empty || ((fifo_level == LW'(1)) && pop)) state_d = StDone;
      StDone:  state_d = StDone;
      default: state_d = StRun;
    endcase
  end

  // FSM: result outputs (registered); an EXIT in the timeout cycle takes precedence.
  always_comb begin
    pass_d      = pass_q;
    timeout_d   = timeout_q;
    exit_code_d = exit_code_q;
    done_d      = done_q || (state_d == StDone);
    if (exit_wr) begin
      pass_d      = (data_i == 32'd1);
      exit_code_d = data_i[31:1];
    end else if (timeout_hit) begin
      timeout_d   = 1'b1;
      pass_d      = 1'b0;
      exit_code_d = EXIT_CODE_TIMEOUT;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cycle_q     <= '0;
      rvalid_q    <= 1'b0;
      rdata_q     <= '0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      timeout_q   <= 1'b0;
      exit_code_q <= '0;
    end else begin
      cycle_q     <= cycle_q + 64'd1;
      rvalid_q    <= gnt_o;
      rdata_q     <= rdata_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      timeout_q   <= timeout_d;
      exit_code_q <= exit_code_d;
    end
  end

  assign rvalid_o    = rvalid_q;
  assign data_o      = rdata_q;
  assign done_o      = done_q;
  assign pass_o      = pass_q;
  assign timeout_o   = timeout_q;
  assign exit_code_o = exit_code_q;

endmodule
